uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 123 ++++++++++++
 tb/tb_uart_rx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with centre sampling; optional even parity via UART_RX_PARITY_EN
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] TERM = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  state_t      state, state_n;
  logic        sync1, rx_sync, rx_prev;
  logic [15:0] clk_count, count_n;
  logic [2:0]  bit_index, idx_n;
  logic [7:0]  rx_shift, shift_n, data_n;
  logic        par_bad, pbad_n, valid_n, ferr_n, perr_n;

  assign rx_busy = state != IDLE;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx_serial;
      rx_sync <= sync1;
      rx_prev <= rx_sync;
    end
  end

  // FSM state, counters, shift register and registered output pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clk_count  <= '0;
      bit_index  <= '0;
      rx_shift   <= '0;
      rx_data    <= '0;
      par_bad    <= 1'b0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      clk_count  <= count_n;
      bit_index  <= idx_n;
      rx_shift   <= shift_n;
      rx_data    <= data_n;
      par_bad    <= pbad_n;
      rx_valid   <= valid_n;
      frame_err  <= ferr_n;
      parity_err <= perr_n;
    end
  end

  // Next-state logic: validate start at mid-bit, sample each bit at its centre
  always_comb begin
    state_n = state;
    count_n = clk_count + 16'd1;
    idx_n   = bit_index;
    shift_n = rx_shift;
    data_n  = rx_data;
    pbad_n  = par_bad;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    perr_n  = 1'b0;
    case (state)
      IDLE: begin
        count_n = '0;
        pbad_n  = 1'b0;
        state_n = (rx_prev && !rx_sync) ? START : IDLE;
      end
      START: if (clk_count == HALF) begin
        count_n = '0;
        idx_n   = '0;
        state_n = rx_sync ? IDLE : DATA;
      end
      DATA: if (clk_count == TERM) begin
        count_n = '0;
        shift_n = {rx_sync, rx_shift[7:1]};
        idx_n   = bit_index + 3'd1;
        state_n = (bit_index == 3'd7) ? AFTER_DATA : DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (clk_count == TERM) begin
        count_n = '0;
        pbad_n  = rx_sync ^ (^rx_shift);
        state_n = STOP;
      end
`endif
      STOP: if (clk_count == TERM) begin
        count_n = '0;
        state_n = IDLE;
        ferr_n  = !rx_sync;
        perr_n  = rx_sync && par_bad;
        valid_n = rx_sync && !par_bad;
        data_n  = (rx_sync && !par_bad) ? rx_shift : rx_data;
      end
      default: begin
        count_n = '0;
        state_n = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frames against a frame-level reference model with a queued scoreboard
module tb_uart_rx;
  localparam int CPB = 10;
`ifdef UART_RX_PARITY_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_serial = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, parity_err;

  uart_rx #(.CLK_FREQ(1000000), .BAUD_RATE(100000)) dut (
    .clk(clk), .rst_n(rst_n), .rx_serial(rx_serial), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_busy(rx_busy), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  logic [7:0] last_good = 8'h00;
  int         busy_cycles = 0;
  int         checks = 0;
  int         failures = 0;
  int         b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Frame-level model: kind is one-hot {parity_err, frame_err, rx_valid}
  task automatic expect_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    exp_t e;
    e.data = d;
    e.kind = !stop_bit ? 3'b010 : (PE && (par_bit != ^d)) ? 3'b100 : 3'b001;
    sb.push_back(e);
  endtask

  task automatic drive_bit(input logic b);
    rx_serial = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    expect_frame(d, stop_bit, par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PE) drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  // Monitor: pop the scoreboard on every output pulse and compare
  always @(negedge clk) begin
    if (rx_busy) busy_cycles++;
    if (!rst_n) last_good = 8'h00;
    else if (rx_valid || frame_err || parity_err) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=%b required=none", {parity_err, frame_err, rx_valid});
      end else begin
        cur = sb.pop_front();
        chk("event_kind", {29'd0, parity_err, frame_err, rx_valid}, {29'd0, cur.kind});
        if (cur.kind == 3'b001) begin
          chk("rx_data", {24'd0, rx_data}, {24'd0, cur.data});
          last_good = cur.data;
        end else chk("held_data", {24'd0, rx_data}, {24'd0, last_good});
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic       bad, par;
    repeat (3) @(negedge clk);
    chk("reset_data", {24'd0, rx_data}, 32'h00);
    chk("reset_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_busy", {31'd0, rx_busy}, 32'd0);
    chk("reset_ferr", {31'd0, frame_err}, 32'd0);
    chk("reset_perr", {31'd0, parity_err}, 32'd0);
    rst_n = 1'b1;
    idle(5);
    b0 = busy_cycles;
    send(8'hA5, 1'b1, ^8'hA5);
    idle(10);
    chk("a5_busy_len", {31'd0, (busy_cycles - b0) >= 93 + 10 * PE && (busy_cycles - b0) <= 97 + 10 * PE}, 32'd1);
    chk("a5_drained", sb.size(), 32'd0);
    send(8'h3C, 1'b1, ^8'h3C);
    send(8'hC3, 1'b1, ^8'hC3);
    idle(15);
    chk("b2b_drained", sb.size(), 32'd0);
    rx_serial = 1'b0;
    repeat (3) @(negedge clk);
    rx_serial = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_rise", {31'd0, rx_busy}, 32'd1);
    repeat (10) @(negedge clk);
    chk("glitch_busy_fall", {31'd0, rx_busy}, 32'd0);
    send(8'h55, 1'b1, ^8'h55);
    idle(10);
    chk("after_glitch_drained", sb.size(), 32'd0);
    send(8'hFF, 1'b0, ^8'hFF);
    rx_serial = 1'b0;
    repeat (30) @(negedge clk);
    chk("low_line_no_retrigger", {31'd0, rx_busy}, 32'd0);
    chk("ferr_drained", sb.size(), 32'd0);
    idle(20);
    chk("ferr_idle", {31'd0, rx_busy}, 32'd0);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i < 4);
    rx_serial = 1'b0;
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_data", {24'd0, rx_data}, 32'h00);
    chk("midrst_valid", {31'd0, rx_valid}, 32'd0);
    chk("midrst_busy", {31'd0, rx_busy}, 32'd0);
    chk("midrst_ferr", {31'd0, frame_err | parity_err}, 32'd0);
    rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    send(8'h81, 1'b1, ^8'h81);
    idle(10);
    chk("after_rst_drained", sb.size(), 32'd0);
`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b0);
    idle(10);
    send(8'h07, 1'b1, 1'b1);
    idle(10);
    chk("parity_drained", sb.size(), 32'd0);
`endif
    for (int n = 0; n < 40; n++) begin
      d   = 8'($urandom);
      bad = $urandom_range(0, 9) == 0;
      par = (^d) ^ ($urandom_range(0, 3) == 0);
      send(d, !bad, par);
      idle(bad ? 10 + $urandom_range(0, 5) : $urandom_range(0, 12));
    end
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
